// File: rtl/acc_frame_receiver.sv
// Frame decoder for the accumulator readout byte stream: hunts for a header,
// assembles 8-byte records into four 16-bit words, and flags footer/overflow/errors.
module acc_frame_receiver #(
  parameter int MAX_RECORDS = 512,
  parameter int COUNT_W     = 10
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [7:0]         DataIn,
  input  logic               DataReady,
  output logic               ReadEnable,
  output logic [15:0]        SampleDQD,
  output logic [15:0]        SampleDID,
  output logic [15:0]        SampleDQ,
  output logic [15:0]        SampleDI,
  output logic               RecordValid,
  input  logic               RecordAccept,
  output logic               FrameStart,
  output logic               FrameDone,
  output logic               FrameError,
  output logic [COUNT_W-1:0] RecordCount,
  output logic               Busy
);

  typedef enum logic [1:0] {HUNT, HDR2, REC, HOLD} state_t;

  state_t      state, stateNext;
  logic [2:0]  byteIdx;
  logic [55:0] recBuf;
  logic        xfer;
  logic        startNext, doneNext, errNext, recLoad;

  assign xfer = DataReady & ReadEnable;

  always_comb begin
    stateNext = state;
    startNext = 1'b0;
    doneNext  = 1'b0;
    errNext   = 1'b0;
    recLoad   = 1'b0;
    case (state)
      HUNT: if (xfer && DataIn == 8'h80) stateNext = HDR2;
      HDR2: if (xfer) begin
        if (DataIn == 8'h02) begin
          stateNext = REC;
          startNext = 1'b1;
        end else if (DataIn != 8'h80) begin
          stateNext = HUNT;
          errNext   = 1'b1;
        end
      end
      REC: if (xfer) begin
        // recBuf[7:0] holds byte 0 of the group while byte 1 is on DataIn
        if (byteIdx == 3'd1 && recBuf[7:0] == 8'h80 && DataIn == 8'h01) begin
          stateNext = HUNT;
          doneNext  = 1'b1;
        end else if (byteIdx == 3'd1 && RecordCount == COUNT_W'(MAX_RECORDS)) begin
          stateNext = HUNT;
          errNext   = 1'b1;
        end else if (byteIdx == 3'd7) begin
          stateNext = HOLD;
          recLoad   = 1'b1;
        end
      end
      HOLD: if (RecordValid && RecordAccept) stateNext = REC;
      default: stateNext = HUNT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= HUNT;
      byteIdx     <= 3'd0;
      recBuf      <= '0;
      ReadEnable  <= 1'b0;
      RecordValid <= 1'b0;
      SampleDQD   <= '0;
      SampleDID   <= '0;
      SampleDQ    <= '0;
      SampleDI    <= '0;
      FrameStart  <= 1'b0;
      FrameDone   <= 1'b0;
      FrameError  <= 1'b0;
      RecordCount <= '0;
      Busy        <= 1'b0;
    end else begin
      state       <= stateNext;
      // ReadEnable/RecordValid follow the registered state so neither depends on DataReady
      ReadEnable  <= (stateNext != HOLD);
      RecordValid <= (stateNext == HOLD);
      FrameStart  <= startNext;
      FrameDone   <= doneNext;
      FrameError  <= errNext;
      if (startNext)
        Busy <= 1'b1;
      else if (doneNext || errNext)
        Busy <= 1'b0;
      if (startNext)
        RecordCount <= '0;
      else if (recLoad)
        RecordCount <= RecordCount + COUNT_W'(1);
      if (state == REC && xfer)
        recBuf <= {recBuf[47:0], DataIn};
      if (stateNext != REC)
        byteIdx <= 3'd0;
      else if (state == REC && xfer)
        byteIdx <= byteIdx + 3'd1;
      if (recLoad)
        {SampleDQD, SampleDID, SampleDQ, SampleDI} <= {recBuf, DataIn};
    end
  end

endmodule

// File: doc/acc_frame_receiver.md
# acc_frame_receiver

Byte-stream frame decoder for the accumulator readout link. It sits at the consuming end of the accumulator storage output and pulls bytes with a DataReady/ReadEnable handshake. It parses each frame (header, 8-byte sample records, footer) and presents each record as four 16-bit channel words with a valid/accept handshake. It also reports frame start, completion, record count and protocol errors. Used for on-chip loopback checking and for downstream consumers of captured data.

## Interface
- MAX_RECORDS, 512, records allowed per frame before overflow error
- COUNT_W, 10, width of RecordCount; must hold MAX_RECORDS

- Clock  in  1  single clock; all logic on its rising edge
- Reset  in  1  synchronous, active-high
- DataIn  in  8  stream byte from storage block
- DataReady  in  1  storage block has a byte available
- ReadEnable  out  1  receiver requests a byte
- SampleDQD, SampleDID, SampleDQ, SampleDI  out  16 each  decoded record words
- RecordValid  out  1  record words valid; held until accepted
- RecordAccept  in  1  sink takes record when RecordValid & RecordAccept
- FrameStart  out  1  1-cycle pulse, header recognised
- FrameDone  out  1  1-cycle pulse, footer recognised
- FrameError  out  1  1-cycle pulse, protocol violation
- RecordCount  out  COUNT_W  records decoded in current/last frame
- Busy  out  1  high from header accepted until FrameDone/FrameError

## Operation
- Transfer: a byte moves on a cycle with DataReady & ReadEnable both high; DataIn is sampled that cycle. ReadEnable is driven from registered state only, never from DataReady.
- Frame format: header 0x80,0x02; then N records; then footer 0x80,0x01. N may be 0.
- Record byte order: DQD[15:8], DQD[7:0], DID hi, DID lo, DQ hi, DQ lo, DI hi, DI lo.
- States:
  - HUNT: consume bytes. On 0x80 go to HDR2.
  - HDR2: 0x02 -> REC, pulse FrameStart, clear RecordCount, set Busy. 0x80 -> stay in HDR2. Any other byte -> HUNT with FrameError.
  - REC: byte index 0..7.
    - At index 1, if bytes 0,1 are 0x80,0x01, the group is the footer: pulse FrameDone, clear Busy, go to HUNT. A DQD word of 0x8001 is therefore always end-of-frame; the upstream block never emits it as data.
    - Else, if RecordCount == MAX_RECORDS, pulse FrameError, clear Busy, go to HUNT; the partial record is discarded.
    - After index 7, load the four Sample words, set RecordValid, increment RecordCount, and go to HOLD.
  - HOLD: ReadEnable low. On RecordValid & RecordAccept, clear RecordValid and return to REC at index 0.
- ReadEnable is high in HUNT, HDR2 and REC; low in HOLD and during Reset.
- RecordCount holds its final value after FrameDone/FrameError until the next header.
- Sample words hold their last value after RecordValid falls.

## Timing
- Reset values: ReadEnable 0, RecordValid 0, all Sample words 0, FrameStart/FrameDone/FrameError 0, RecordCount 0, Busy 0, state HUNT, byte index 0.
- Reset mid-frame: next cycle all outputs are at reset values and the partial record is dropped. No FrameError is raised.
- Pulse timing:
  - FrameStart pulses the cycle after the 0x02 transfer.
  - FrameDone pulses the cycle after the 0x01 transfer.
  - FrameError pulses the cycle after the offending transfer.
- RecordValid rises the cycle after the 8th byte transfer.
- With RecordAccept tied high, RecordValid is a 1-cycle pulse and ReadEnable is low for exactly 1 cycle per record. Sustained throughput is 8 bytes per 9 cycles.
- Accept on the same cycle RecordValid rises: ReadEnable returns high on the next cycle.
- DataReady gaps: the receiver waits indefinitely with no timeout. Byte index and state are unchanged.

## Test plan
- Frame 80 02 | 12 34 56 78 9A BC DE F0 | 80 01, DataReady constant, accept high -> FrameStart; one RecordValid with DQD=0x1234, DID=0x5678, DQ=0x9ABC, DI=0xDEF0; FrameDone; RecordCount=1; Busy falls.
- Bytes 80 05 then a valid 1-record frame -> FrameError once, no RecordValid for the bad bytes; the second frame decodes with RecordCount=1. Also 80 80 02 is accepted as a header.
- Three-record frame, RecordAccept held low 5 cycles after each RecordValid -> ReadEnable low throughout each hold; all 3 records bit-exact, in order; RecordCount=3.
- MAX_RECORDS=4, frame with 5 records -> 4 RecordValid; FrameError the cycle after byte 2 of record 5; state returns to HUNT; RecordCount=4.
- Reset asserted after byte 5 of a record -> all outputs zero next cycle; a following full frame decodes correctly with RecordCount=1.
- 80 02 80 01 with DataReady toggling randomly -> FrameStart, FrameDone, RecordCount=0, no RecordValid, no FrameError.
